// File: rtl/tlc_pkg.sv
// Shared types for the traffic light controller design.
//   ped_req_state_t : pedestrian request FSM states (IDLE / PENDING / SERVED)
//   light_t         : lamp encodings used across the TLC datapath
package tlc_pkg;

    typedef enum logic [1:0] {
        REQ_IDLE    = 2'd0,
        REQ_PENDING = 2'd1,
        REQ_SERVED  = 2'd2
    } ped_req_state_t;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } light_t;

endpackage

// File: rtl/ped_button_channel.sv
// One pedestrian button channel: 2-flop synchroniser, debouncer, stuck-button
// monitor and request FSM.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   btn_raw   : raw asynchronous, bouncy push-button
//   walk      : walk indication from the controller for this crossing
//   ped       : registered request level, high while a request is pending
//   stuck     : registered stuck-button fault
module ped_button_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned STUCK_CYCLES    = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic walk,
    output logic ped,
    output logic stuck
);
    import tlc_pkg::*;

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ST_W = $clog2(STUCK_CYCLES + 1);
    // db_cnt reaching this value on the next increment means the level is accepted
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STUCK_CYCLES);

    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic            stable_dly_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [ST_W-1:0] st_cnt_q, st_cnt_d;
    logic            stuck_q, stuck_d;
    logic            ped_q, ped_d;
    logic            press;
    ped_req_state_t  state_q, state_d;

    // Debouncer: count consecutive cycles the synchronised level disagrees
    // with the accepted level; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (s2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = ~stable_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign press = stable_q & ~stable_dly_q;

    // Stuck monitor: saturating count of debounced-pressed cycles.
    always_comb begin
        st_cnt_d = st_cnt_q;
        if (!stable_q) begin
            st_cnt_d = '0;
        end else if (st_cnt_q != ST_MAX) begin
            st_cnt_d = st_cnt_q + 1'b1;
        end
        stuck_d = (st_cnt_d == ST_MAX);
    end

    // Request FSM. A press coinciding with walk is dropped: the crossing is
    // already being served. Stuck wins over walk in PENDING.
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ_IDLE: begin
                if (press && !walk && !stuck_q) begin
                    state_d = REQ_PENDING;
                end
            end
            REQ_PENDING: begin
                if (stuck_q) begin
                    state_d = REQ_IDLE;
                end else if (walk) begin
                    state_d = REQ_SERVED;
                end
            end
            REQ_SERVED: begin
                if (!walk) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
        ped_d = (state_d == REQ_PENDING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            db_cnt_q     <= '0;
            st_cnt_q     <= '0;
            stuck_q      <= 1'b0;
            state_q      <= REQ_IDLE;
            ped_q        <= 1'b0;
        end else begin
            s1_q         <= btn_raw;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
            st_cnt_q     <= st_cnt_d;
            stuck_q      <= stuck_d;
            state_q      <= state_d;
            ped_q        <= ped_d;
        end
    end

    assign ped   = ped_q;
    assign stuck = stuck_q;

endmodule

// File: rtl/ped_request_conditioner.sv
// Pedestrian request front-end for the traffic light controller. Conditions
// the EW and NS raw push-buttons into held request levels that are retired by
// the matching walk indication, and flags stuck buttons.
// Ports:
//   clk, rst               : system clock, synchronous active-high reset
//   btn_ew_raw, btn_ns_raw : raw asynchronous pedestrian buttons
//   walk_ew, walk_ns       : walk indications from the controller
//   ped_ew, ped_ns         : registered request levels to the controller
//   stuck_ew, stuck_ns     : registered stuck-button faults
module ped_request_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned STUCK_CYCLES    = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_ew_raw,
    input  logic btn_ns_raw,
    input  logic walk_ew,
    input  logic walk_ns,
    output logic ped_ew,
    output logic ped_ns,
    output logic stuck_ew,
    output logic stuck_ns
);
    import tlc_pkg::*;

    ped_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ew (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_ew_raw),
        .walk    (walk_ew),
        .ped     (ped_ew),
        .stuck   (stuck_ew)
    );

    ped_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ns (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_ns_raw),
        .walk    (walk_ns),
        .ped     (ped_ns),
        .stuck   (stuck_ns)
    );

endmodule
